// File: rtl/clock_monitor_100khz.sv
// Receive-side monitor for the divided 100 kHz clock, sampled as data in the 1 MHz domain.
// Produces edge strobes, half-period/period measurement, and LOCKED/FAULT health status.
module clock_monitor_100khz #(
    parameter int EXP_HALF   = 5,
    parameter int TOL        = 1,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic       CLK_1MHZ_IN,
    input  logic       RESET_IN,
    input  logic       CLK_100KHZ_IN,
    output logic       RISE_STROBE_OUT,
    output logic       FALL_STROBE_OUT,
    output logic       LOCKED_OUT,
    output logic       FAULT_OUT,
    output logic [7:0] PERIOD_OUT,
    output logic [7:0] FAULT_COUNT_OUT
);
    localparam int HC_W = $clog2(TIMEOUT + 1);
    localparam int GC_W = $clog2(LOCK_COUNT + 1);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    logic            s1, s2, s3;
    logic [HC_W-1:0] hc;
    logic [7:0]      pc;
    logic [GC_W-1:0] gc, gc_n;
    logic [1:0]      state, state_n;
    logic            first_edge;
    logic            to_done;

    logic rise, fall, edge_det, to_hit, timeout_evt, eval, h_good, good, bad;

    always_comb begin
        rise        = s2 & ~s3;
        fall        = ~s2 & s3;
        edge_det    = rise | fall;
        // An edge landing on the timeout cycle wins, but is treated as a fresh start.
        to_hit      = (hc == HC_W'(TIMEOUT)) && !to_done;
        timeout_evt = to_hit && !edge_det;
        eval        = edge_det && !first_edge && !to_hit;
        h_good      = (int'(hc) >= EXP_HALF - TOL) && (int'(hc) <= EXP_HALF + TOL);
        good        = eval && h_good;
        bad         = (eval && !h_good) || timeout_evt;

        gc_n = gc;
        if (bad)
            gc_n = '0;
        else if (good && (gc != GC_W'(LOCK_COUNT)))
            gc_n = gc + 1'b1;

        state_n = state;
        case (state)
            ST_SEARCH: if (gc_n == GC_W'(LOCK_COUNT)) state_n = ST_LOCKED;
            ST_LOCKED: if (bad) state_n = ST_FAULT;
            ST_FAULT:  if (gc_n == GC_W'(LOCK_COUNT)) state_n = ST_LOCKED;
            default:   state_n = ST_SEARCH;
        endcase
    end

    always_ff @(posedge CLK_1MHZ_IN) begin
        if (RESET_IN) begin
            s1              <= 1'b0;
            s2              <= 1'b0;
            s3              <= 1'b0;
            hc              <= '0;
            pc              <= '0;
            gc              <= '0;
            state           <= ST_SEARCH;
            first_edge      <= 1'b1;
            to_done         <= 1'b0;
            RISE_STROBE_OUT <= 1'b0;
            FALL_STROBE_OUT <= 1'b0;
            LOCKED_OUT      <= 1'b0;
            FAULT_OUT       <= 1'b0;
            PERIOD_OUT      <= '0;
            FAULT_COUNT_OUT <= '0;
        end else begin
            s1 <= CLK_100KHZ_IN;
            s2 <= s1;
            s3 <= s2;
            RISE_STROBE_OUT <= rise;
            FALL_STROBE_OUT <= fall;

            if (edge_det)
                hc <= HC_W'(1);
            else if (hc != HC_W'(TIMEOUT))
                hc <= hc + 1'b1;

            if (rise)
                pc <= 8'd1;
            else if (pc != 8'hFF)
                pc <= pc + 1'b1;

            // The first rise after reset/timeout has no valid start point to measure from.
            if (rise && !first_edge && !to_hit)
                PERIOD_OUT <= pc;

            if (edge_det)
                to_done <= 1'b0;
            else if (to_hit)
                to_done <= 1'b1;

            if (timeout_evt)
                first_edge <= 1'b1;
            else if (edge_det)
                first_edge <= 1'b0;

            if ((state == ST_LOCKED) && bad && (FAULT_COUNT_OUT != 8'hFF))
                FAULT_COUNT_OUT <= FAULT_COUNT_OUT + 1'b1;

            gc         <= gc_n;
            state      <= state_n;
            LOCKED_OUT <= (state_n == ST_LOCKED);
            FAULT_OUT  <= (state_n == ST_FAULT);
        end
    end
endmodule
